spi_ram_master: RTL and testbench

Host-side SPI master that drives the spi_ram slave (SPI slave plus single-port RAM) directly upstream of it. It accepts one byte-level RAM command per valid/ready handshake and serialises it into the slave's single-clock frame on ss_n/mosi. For read-data commands it captures the 8-bit reply from miso and returns it as a one-cycle response. Master and slave share one clock: mosi and ss_n are registered on the rising edge of clk, and miso is sampled on the rising edge.

---
 rtl/spi_ram_master.sv | 140 ++++++++++++++
 tb/tb_spi_ram_master.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_master.sv
// ----------------------------------------------------------------------------
// spi_ram_master
//
// Host-side SPI master for the spi_ram slave. Takes one byte-level RAM command
// per valid/ready handshake, sends it as an 11-bit frame (MSB first) on
// ss_n/mosi and, for read-data commands, captures the 8-bit reply from miso.
// Master and slave share one clock: ss_n and mosi are registered on the rising
// edge of clk, and miso is sampled on the rising edge.
//
// Frame layout: {cmd_op[1], cmd_op[1:0], payload[7:0]}; payload is 8'h00 for
// op 11 (read data).
//
// Parameters:
//   MISO_DELAY  cycles between the last mosi bit and the first miso bit (1..15)
//   GAP_CYCLES  minimum cycles ss_n is held high between frames         (1..15)
//
// Ports:
//   clk        system clock, shared with spi_ram
//   rst        asynchronous active-high reset
//   cmd_valid  host command valid
//   cmd_ready  master can accept a command (IDLE only)
//   cmd_op     00 wr addr, 01 wr data, 10 rd addr, 11 rd data
//   cmd_data   address or data byte (ignored for op 11)
//   rsp_valid  one-cycle pulse, read byte available
//   rsp_data   captured read byte, held until the next response
//   busy       high in any state other than IDLE
//   ss_n       slave select, active low
//   mosi       serial data to spi_ram
//   miso       serial data from spi_ram
// ----------------------------------------------------------------------------
module spi_ram_master #(
    parameter int unsigned MISO_DELAY = 2,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       ss_n,
    output logic       mosi,
    input  logic       miso
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SEND,
        WAIT,
        RECV,
        GAP
    } state_t;

    localparam logic [3:0] SEND_LAST = 4'd10;
    localparam logic [3:0] RECV_LAST = 4'd7;
    localparam logic [3:0] WAIT_LAST = 4'(MISO_DELAY - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  bit_cnt;
    logic [3:0]  bit_cnt_nxt;
    logic [10:0] frame;
    logic [7:0]  rx_shift;
    logic        accept;
    logic        recv_done;
    logic        ss_n_nxt;
    logic        mosi_nxt;

    assign accept    = cmd_valid && (state == IDLE);
    assign recv_done = (state == RECV) && (bit_cnt == RECV_LAST);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Next-state, counter and serial-line decode.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt + 4'd1;
        ss_n_nxt    = 1'b1;
        mosi_nxt    = 1'b0;

        case (state)
            IDLE: if (accept) state_nxt = LEAD;
            LEAD: state_nxt = SEND;
            SEND: if (bit_cnt == SEND_LAST)
                      state_nxt = (frame[9:8] == 2'b11) ? WAIT : GAP;
            WAIT: if (bit_cnt == WAIT_LAST) state_nxt = RECV;
            RECV: if (bit_cnt == RECV_LAST) state_nxt = GAP;
            GAP:  if (bit_cnt == GAP_LAST)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // The counter restarts on every state change and stays parked in IDLE.
        if (state_nxt != state || state_nxt == IDLE)
            bit_cnt_nxt = 4'd0;

        // Lines are computed for the next cycle so they leave a flop cleanly.
        ss_n_nxt = !(state_nxt inside {LEAD, SEND, WAIT, RECV});
        if (state_nxt == SEND)
            mosi_nxt = frame[SEND_LAST - bit_cnt_nxt];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            frame     <= 11'd0;
            rx_shift  <= 8'h00;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            ss_n      <= 1'b1;
            mosi      <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            ss_n      <= ss_n_nxt;
            mosi      <= mosi_nxt;
            rsp_valid <= recv_done;

            if (accept)
                frame <= {cmd_op[1], cmd_op, (cmd_op == 2'b11) ? 8'h00 : cmd_data};

            if (state == RECV)
                rx_shift <= {rx_shift[6:0], miso};

            // The last reply bit is still on miso, so fold it in directly.
            if (recv_done)
                rsp_data <= {rx_shift[6:0], miso};
        end
    end

endmodule

// File: tb/tb_spi_ram_master.sv
// ----------------------------------------------------------------------------
// tb_spi_ram_master
//
// Self-checking bench for spi_ram_master. A behavioural spi_ram slave decodes
// the frames seen on ss_n/mosi, keeps its own 256-byte RAM and drives read
// replies on miso. The stimulus side keeps a reference RAM and pushes the
// expected frame and expected read byte into queues as each command is
// accepted; the slave and response monitors pop and compare.
// ----------------------------------------------------------------------------
module tb_spi_ram_master;

    localparam int MISO_DELAY = 2;
    localparam int GAP_CYCLES = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       ss_n;
    logic       mosi;
    logic       miso = 1'b0;

    spi_ram_master #(
        .MISO_DELAY(MISO_DELAY),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .busy     (busy),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard queues and reference model (stimulus side).
    logic [10:0] exp_frame[$];
    logic [7:0]  exp_rsp[$];
    logic [7:0]  ref_mem[256];
    logic [7:0]  ref_addr = 8'h00;
    logic [7:0]  last_rsp = 8'h00;

    // Behavioural slave state.
    logic [7:0]  smem[256];
    logic [7:0]  saddr = 8'h00;
    logic [10:0] sframe = 11'd0;
    logic [7:0]  reply = 8'h00;
    int          lowcnt = 0;
    int          hicnt = 0;
    bit          post_frame = 0;
    bit          last_read = 0;
    int          mosi_bad = 0;

    // Slave and response monitor, sampling away from the active edge.
    always @(negedge clk) begin
        logic [10:0] ef;
        int          k;
        int          exp_len;
        if (rst) begin
            lowcnt     = 0;
            hicnt      = 0;
            post_frame = 0;
            last_read  = 0;
            miso       = 1'b0;
        end else if (!ss_n) begin
            if (lowcnt == 0) begin
                if (post_frame) check("gap_high_cycles", hicnt, GAP_CYCLES + 1);
                post_frame = 0;
            end
            if (lowcnt >= 1 && lowcnt <= 11) sframe = {sframe[9:0], mosi};
            else if (mosi) mosi_bad++;
            if (lowcnt == 11) reply = smem[saddr];
            k = lowcnt - (12 + MISO_DELAY);
            if (sframe[9:8] == 2'b11 && k >= 0 && k < 8) miso = reply[7 - k];
            else miso = 1'($urandom_range(0, 1));
            lowcnt++;
        end else begin
            if (lowcnt > 0) begin
                if (exp_frame.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                    ef = sframe;
                end else begin
                    ef = exp_frame.pop_front();
                    check("frame_bits", sframe, ef);
                end
                exp_len = (ef[9:8] == 2'b11) ? 20 + MISO_DELAY : 12;
                check("ss_n_low_cycles", lowcnt, exp_len);
                case (sframe[9:8])
                    2'b00, 2'b10: saddr = sframe[7:0];
                    2'b01:        smem[saddr] = sframe[7:0];
                    default:      ;
                endcase
                last_read  = (sframe[9:8] == 2'b11);
                post_frame = 1;
                lowcnt     = 0;
                hicnt      = 0;
            end
            if (mosi) mosi_bad++;
            if (post_frame) begin
                if (hicnt == 0) check("rsp_valid_slot", rsp_valid, last_read);
                if (hicnt == GAP_CYCLES - 1) check("ready_low_in_gap", cmd_ready, 0);
                if (hicnt == GAP_CYCLES) check("ready_after_gap", cmd_ready, 1);
            end
            hicnt++;
            miso = 1'($urandom_range(0, 1));
        end
        if (!rst && rsp_valid) begin
            if (exp_rsp.size() == 0) check("unexpected_rsp", 1, 0);
            else check("rsp_data", rsp_data, exp_rsp.pop_front());
        end
    end

    // Issue one command; inputs change 1 time unit after the rising edge.
    // With scramble set, cmd_valid stays high and op/data are randomised
    // until the master is ready again, so the caller must issue next at once.
    task automatic issue(input logic [1:0] op, input logic [7:0] data, input bit scramble);
        int n = 0;
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        exp_frame.push_back({op[1], op, (op == 2'b11) ? 8'h00 : data});
        case (op)
            2'b00, 2'b10: ref_addr = data;
            2'b01:        ref_mem[ref_addr] = data;
            default: begin
                exp_rsp.push_back(ref_mem[ref_addr]);
                last_rsp = ref_mem[ref_addr];
            end
        endcase
        check("ss_n_low_after_accept", ss_n, 0);
        check("busy_after_accept", busy, 1);
        if (scramble) begin
            n = 0;
            while (!cmd_ready && n < 100) begin
                cmd_op   = 2'($urandom_range(0, 3));
                cmd_data = 8'($urandom_range(0, 255));
                @(posedge clk); #1;
                n++;
            end
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'h00;
            smem[i]    = 8'h00;
        end

        // Reset values.
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss_n", ss_n, 1);
        check("rst_mosi", mosi, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of SEND aborts the frame immediately.
        issue(2'b00, 8'h55, 0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_ss_n", ss_n, 1);
        check("abort_busy", busy, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        exp_frame.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("abort_ready_after_release", cmd_ready, 1);
        @(posedge clk); #1;

        // Directed frames, then end-to-end RAM traffic through the slave model.
        issue(2'b00, 8'hFF, 0);
        issue(2'b01, 8'hA5, 0);
        issue(2'b10, 8'hFF, 0);
        issue(2'b00, 8'h10, 0);
        issue(2'b01, 8'h3C, 0);
        issue(2'b10, 8'h10, 0);
        issue(2'b11, 8'hEE, 0);
        issue(2'b00, 8'hF0, 0);
        issue(2'b01, 8'h81, 0);
        issue(2'b10, 8'hF0, 0);
        issue(2'b11, 8'h00, 0);
        issue(2'b10, 8'hFF, 0);
        issue(2'b11, 8'h00, 0);
        issue(2'b10, 8'h77, 0);
        issue(2'b11, 8'h00, 0);

        // cmd_valid held high with inputs changing during each frame.
        issue(2'b00, 8'h20, 1);
        issue(2'b01, 8'hC3, 1);
        issue(2'b10, 8'h20, 1);
        issue(2'b11, 8'h5A, 1);
        cmd_valid = 1'b0;

        // Random command mix.
        for (int i = 0; i < 12; i++)
            issue(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 0);

        // Drain outstanding frames and responses.
        n = 0;
        while ((exp_frame.size() != 0 || exp_rsp.size() != 0 || !cmd_ready) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("frames_drained", exp_frame.size(), 0);
        check("rsps_drained", exp_rsp.size(), 0);
        check("mosi_idle_zero", mosi_bad, 0);
        check("rsp_data_held", rsp_data, last_rsp);
        check("final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
